mac_seq_ctrl: RTL and testbench

Sequencer for one bit-serial MAC unit (8-bit signed activation/weight, 20-bit accumulator, reduced-precision weight modes). It accepts a dot-product job (vector length, precision level) and pulls operand pairs over a valid/ready stream. It drives the MAC's enable, clear and precision inputs, flushes the final product into the accumulator, and returns the 20-bit result over a valid/ready output. It sits between the operand buffer and the MAC array top level.

---
 rtl/mac_seq_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_mac_seq_ctrl.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: sequencer for a single bit-serial MAC unit.
// Accepts a dot-product job, streams operand pairs into the MAC one word at a
// time, flushes the final product with a zero word and hands back the result.
module mac_seq_ctrl #(
   parameter int LEN_W = 8,
   parameter int ACC_W = 20
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] vec_len,
   input  logic [1:0]       prec_level,
   output logic             busy,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_act,
   input  logic [7:0]       in_wgt,
   output logic [7:0]       mac_act,
   output logic [7:0]       mac_wgt,
   output logic             mac_en,
   output logic             mac_clr,
   output logic [1:0]       mac_prec,
   input  logic [ACC_W-1:0] mac_result,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_result,
   output logic [LEN_W-1:0] out_pairs
);

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      FETCH,
      RUN,
      DRAIN,
      SETTLE,
      DONE
   } state_t;

   state_t           state;
   state_t           next_state;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] pair_cnt;
   logic [2:0]       bit_cnt;
   logic [2:0]       bit_last_val;
   logic             bit_last;
   logic             pairs_left;
   logic             take;
   logic             zero_job;

   assign bit_last   = (bit_cnt == bit_last_val);
   assign pairs_left = (pair_cnt != len_q);
   assign take       = in_valid & in_ready;
   assign zero_job   = (state == IDLE) && start && (vec_len == '0);
   assign busy       = (state != IDLE);
   assign out_valid  = (state == DONE);

   // Index of the final bit-step of a word for the latched precision code
   always_comb begin
      bit_last_val = 3'd7;
      case (mac_prec)
         2'b00:   bit_last_val = 3'd7;
         2'b01:   bit_last_val = 3'd3;
         2'b10:   bit_last_val = 3'd1;
         default: bit_last_val = 3'd3;
      endcase
   end

   // Next-state decode plus the handshake and MAC-enable strobes
   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      mac_en     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               next_state = (vec_len == '0) ? DONE : CLEAR;
            end
         end
         CLEAR: begin
            next_state = FETCH;
         end
         FETCH: begin
            in_ready = 1'b1;
            if (in_valid) begin
               next_state = RUN;
            end
         end
         RUN: begin
            mac_en = 1'b1;
            if (bit_last) begin
               if (pairs_left) begin
                  in_ready = 1'b1;
                  if (!in_valid) begin
                     next_state = FETCH;
                  end
               end else begin
                  next_state = DRAIN;
               end
            end
         end
         DRAIN: begin
            mac_en = 1'b1;
            if (bit_last) begin
               next_state = SETTLE;
            end
         end
         SETTLE: begin
            next_state = DONE;
         end
         DONE: begin
            if (out_ready) begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // State register; the MAC clear is registered so it is held high out of reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         mac_clr <= 1'b1;
      end else begin
         state   <= next_state;
         mac_clr <= (next_state == CLEAR);
      end
   end

   // Job parameters are captured once per accepted start and then frozen
   always_ff @(posedge clk) begin
      if (rst) begin
         len_q    <= '0;
         mac_prec <= 2'b00;
      end else if ((state == IDLE) && start) begin
         len_q    <= vec_len;
         mac_prec <= prec_level;
      end
   end

   // Bit-step counter within a word and count of pairs taken so far
   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt  <= 3'd0;
         pair_cnt <= '0;
      end else if (state == CLEAR) begin
         bit_cnt  <= 3'd0;
         pair_cnt <= '0;
      end else begin
         if (take) begin
            pair_cnt <= pair_cnt + LEN_W'(1);
         end
         if ((state == RUN) || (state == DRAIN)) begin
            bit_cnt <= bit_last ? 3'd0 : bit_cnt + 3'd1;
         end
      end
   end

   // Operand hold registers; zeroed for the drain word that flushes the last product
   always_ff @(posedge clk) begin
      if (rst) begin
         mac_act <= 8'd0;
         mac_wgt <= 8'd0;
      end else if (state == CLEAR) begin
         mac_act <= 8'd0;
         mac_wgt <= 8'd0;
      end else if (take) begin
         mac_act <= in_act;
         mac_wgt <= in_wgt;
      end else if ((state == RUN) && bit_last && !pairs_left) begin
         mac_act <= 8'd0;
         mac_wgt <= 8'd0;
      end
   end

   // Result capture after the MAC has settled; empty jobs report zero
   always_ff @(posedge clk) begin
      if (rst) begin
         out_result <= '0;
         out_pairs  <= '0;
      end else if (zero_job) begin
         out_result <= '0;
         out_pairs  <= '0;
      end else if (state == SETTLE) begin
         out_result <= mac_result;
         out_pairs  <= pair_cnt;
      end
   end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb_mac_seq_ctrl: directed self-checking bench for mac_seq_ctrl, with a
// behavioural stand-in for the bit-serial MAC that folds each finished
// product into the accumulator at the start of the following word.
module tb_mac_seq_ctrl;

   localparam int LEN_W = 8;
   localparam int ACC_W = 20;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [LEN_W-1:0] vec_len;
   logic [1:0]       prec_level;
   logic             busy;
   logic             in_valid;
   logic             in_ready;
   logic [7:0]       in_act;
   logic [7:0]       in_wgt;
   logic [7:0]       mac_act;
   logic [7:0]       mac_wgt;
   logic             mac_en;
   logic             mac_clr;
   logic [1:0]       mac_prec;
   logic [ACC_W-1:0] mac_result;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_result;
   logic [LEN_W-1:0] out_pairs;

   int checks   = 0;
   int failures = 0;

   int act_v[8];
   int wgt_v[8];

   int               r_lat;
   int               r_en;
   int               r_rdy;
   int               r_rdy_bad;
   int               r_gap;
   int               r_prec_bad;
   int               r_busy_bad;
   int               r_unstable;
   int               r_post_bad;
   int               r_vcnt;
   logic [ACC_W-1:0] r_res;
   logic [LEN_W-1:0] r_pairs;

   // Free-running clock
   always #5 clk = ~clk;

   mac_seq_ctrl #(.LEN_W(LEN_W), .ACC_W(ACC_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .vec_len    (vec_len),
      .prec_level (prec_level),
      .busy       (busy),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_act     (in_act),
      .in_wgt     (in_wgt),
      .mac_act    (mac_act),
      .mac_wgt    (mac_wgt),
      .mac_en     (mac_en),
      .mac_clr    (mac_clr),
      .mac_prec   (mac_prec),
      .mac_result (mac_result),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_pairs  (out_pairs)
   );

   logic signed [ACC_W-1:0] m_acc;
   logic signed [ACC_W-1:0] m_pend;
   logic        [2:0]       m_k;
   logic        [2:0]       m_last;
   logic signed [15:0]      m_prod;

   // MAC stand-in: word length from the precision code, product of operands
   always_comb begin
      m_last = 3'd3;
      if (mac_prec == 2'b00) m_last = 3'd7;
      else if (mac_prec == 2'b10) m_last = 3'd1;
      m_prod = $signed(mac_act) * $signed(mac_wgt);
   end

   // MAC stand-in: clear on mac_clr, add the previous product at each word start
   always @(posedge clk) begin
      if (mac_clr === 1'b1) begin
         m_acc  <= '0;
         m_pend <= '0;
         m_k    <= 3'd0;
      end else if (mac_en === 1'b1) begin
         if (m_k == 3'd0) begin
            m_acc  <= m_acc + m_pend;
            m_pend <= ACC_W'(m_prod);
         end
         m_k <= (m_k == m_last) ? 3'd0 : m_k + 3'd1;
      end
   end

   assign mac_result = m_acc;

   // Runs one job from start to result handshake and records what was observed
   task automatic applyStimulus(input int n, input logic [1:0] p, input int refuse,
                                input int refuse_pair, input int hold, input bit poke);
      int t;
      int idx;
      int nb;
      int en_cnt;
      int zero_run;
      int refused;
      bit withhold;
      bit accepted;
      bit finished;
      nb = (p == 2'b00) ? 8 : ((p == 2'b10) ? 2 : 4);
      r_lat = -1; r_en = 0; r_rdy = 0; r_rdy_bad = 0; r_gap = 0; r_prec_bad = 0;
      r_busy_bad = 0; r_unstable = 0; r_post_bad = 0; r_vcnt = 0;
      r_res = '0; r_pairs = '0;
      idx = 0; en_cnt = 0; zero_run = 0; refused = 0;
      accepted = 1'b0; finished = 1'b0;
      @(negedge clk);
      start = 1'b1;
      vec_len = LEN_W'(n);
      prec_level = p;
      out_ready = (hold == 0);
      t = 0;
      while (!finished && t < 2000) begin
         if (accepted) begin
            if (out_valid !== 1'b0 || busy !== 1'b0) r_post_bad++;
            finished = 1'b1;
         end else begin
            withhold = (idx == refuse_pair) && (refused < refuse);
            if (idx < n && !withhold) begin
               in_valid = 1'b1;
               in_act = 8'(act_v[idx]);
               in_wgt = 8'(wgt_v[idx]);
            end else begin
               in_valid = 1'b0;
               in_act = 8'hA5;
               in_wgt = 8'h5A;
            end
            if (in_ready === 1'b1) r_rdy++;
            if (in_ready === 1'b1 && withhold) refused++;
            if (in_valid && in_ready === 1'b1) idx++;
            if (mac_en === 1'b1) begin
               if (en_cnt > 0 && zero_run > r_gap) r_gap = zero_run;
               zero_run = 0;
               if (in_ready === 1'b1 && (en_cnt % nb) != nb - 1) r_rdy_bad++;
               en_cnt++;
            end else if (en_cnt > 0) begin
               zero_run++;
            end
            if (t >= 1 && r_lat < 0 && busy !== 1'b1) r_busy_bad++;
            if (out_valid === 1'b1) begin
               if (r_lat < 0) begin
                  r_lat = t;
                  r_res = out_result;
                  r_pairs = out_pairs;
                  if (mac_prec !== p) r_prec_bad++;
               end else if (out_result !== r_res || out_pairs !== r_pairs) begin
                  r_unstable++;
               end
               r_vcnt++;
               out_ready = (r_vcnt > hold);
               if (out_ready) accepted = 1'b1;
            end
         end
         if (!finished) begin
            @(negedge clk);
            t++;
            if (t == 1) begin
               start = 1'b0;
               vec_len = '1;
               prec_level = ~p;
            end
            if (poke && t == 5) start = 1'b1;
            if (poke && t == 6) start = 1'b0;
         end
      end
      in_valid = 1'b0;
      r_en = en_cnt;
      checks++;
      if (!finished) begin
         failures++;
         $display("[TB] FAIL job_timeout got=no_handshake exp=handshake_within_2000_cycles");
      end
   endtask

   // Reset values while rst is held, then mac_clr release in IDLE
   task automatic test_reset();
      rst = 1'b1; start = 1'b0; vec_len = '0; prec_level = 2'b00;
      in_valid = 1'b0; in_act = 8'd0; in_wgt = 8'd0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, in_ready, mac_en, out_valid} !== 4'b0000) begin
         failures++;
         $display("[TB] FAIL reset_strobes got=%b exp=0000", {busy, in_ready, mac_en, out_valid});
      end
      checks++;
      if ({mac_act, mac_wgt, mac_prec} !== 18'd0) begin
         failures++;
         $display("[TB] FAIL reset_mac_side got=%h/%h/%b exp=0/0/0", mac_act, mac_wgt, mac_prec);
      end
      checks++;
      if (out_result !== '0 || out_pairs !== '0) begin
         failures++;
         $display("[TB] FAIL reset_result got=%0d/%0d exp=0/0", out_result, out_pairs);
      end
      checks++;
      if (mac_clr !== 1'b1) begin
         failures++;
         $display("[TB] FAIL reset_mac_clr got=%b exp=1", mac_clr);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (mac_clr !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL idle_after_reset got=clr%b busy%b exp=clr0 busy0", mac_clr, busy);
      end
   endtask

   // One pair at full precision: 1+1+8+8+1+1 = 20 cycles, 16 enable cycles
   task automatic test_single();
      act_v[0] = 3; wgt_v[0] = 5;
      applyStimulus(1, 2'b00, 0, 0, 0, 1'b0);
      checks++;
      if (r_res !== ACC_W'(15) || r_pairs !== LEN_W'(1)) begin
         failures++;
         $display("[TB] FAIL single_result got=%0d/%0d exp=15/1", $signed(r_res), r_pairs);
      end
      checks++;
      if (r_lat !== 20) begin
         failures++;
         $display("[TB] FAIL single_latency got=%0d exp=20", r_lat);
      end
      checks++;
      if (r_en !== 16) begin
         failures++;
         $display("[TB] FAIL single_mac_en got=%0d exp=16", r_en);
      end
      checks++;
      if (r_prec_bad !== 0 || r_busy_bad !== 0 || r_post_bad !== 0) begin
         failures++;
         $display("[TB] FAIL single_ctrl got=%0d/%0d/%0d exp=0/0/0", r_prec_bad, r_busy_bad, r_post_bad);
      end
   endtask

   // Three pairs streamed with no bubble; a start mid-job must be ignored
   task automatic test_back_to_back();
      act_v[0] = 3;  wgt_v[0] = 5;
      act_v[1] = -2; wgt_v[1] = 7;
      act_v[2] = 10; wgt_v[2] = -4;
      applyStimulus(3, 2'b00, 0, 0, 0, 1'b1);
      checks++;
      if (r_res !== ACC_W'(-39) || r_pairs !== LEN_W'(3)) begin
         failures++;
         $display("[TB] FAIL b2b_result got=%0d/%0d exp=-39/3", $signed(r_res), r_pairs);
      end
      checks++;
      if (r_lat !== 36) begin
         failures++;
         $display("[TB] FAIL b2b_latency got=%0d exp=36", r_lat);
      end
      checks++;
      if (r_en !== 32 || r_gap !== 0) begin
         failures++;
         $display("[TB] FAIL b2b_mac_en got=%0d gap%0d exp=32 gap0", r_en, r_gap);
      end
      checks++;
      if (r_rdy !== 3 || r_rdy_bad !== 0) begin
         failures++;
         $display("[TB] FAIL b2b_in_ready got=%0d bad%0d exp=3 bad0", r_rdy, r_rdy_bad);
      end
      checks++;
      if (r_prec_bad !== 0 || r_busy_bad !== 0 || r_post_bad !== 0) begin
         failures++;
         $display("[TB] FAIL b2b_ctrl got=%0d/%0d/%0d exp=0/0/0", r_prec_bad, r_busy_bad, r_post_bad);
      end
   endtask

   // Pair 2 withheld on the last-bit cycle and five FETCH cycles: 6 frozen cycles
   task automatic test_stall();
      act_v[0] = 3;  wgt_v[0] = 5;
      act_v[1] = -2; wgt_v[1] = 7;
      act_v[2] = 10; wgt_v[2] = -4;
      applyStimulus(3, 2'b00, 6, 1, 0, 1'b0);
      checks++;
      if (r_res !== ACC_W'(-39)) begin
         failures++;
         $display("[TB] FAIL stall_result got=%0d exp=-39", $signed(r_res));
      end
      checks++;
      if (r_lat !== 42) begin
         failures++;
         $display("[TB] FAIL stall_latency got=%0d exp=42", r_lat);
      end
      checks++;
      if (r_en !== 32 || r_gap !== 6) begin
         failures++;
         $display("[TB] FAIL stall_mac_en got=%0d gap%0d exp=32 gap6", r_en, r_gap);
      end
      checks++;
      if (r_rdy !== 9 || r_rdy_bad !== 0) begin
         failures++;
         $display("[TB] FAIL stall_in_ready got=%0d bad%0d exp=9 bad0", r_rdy, r_rdy_bad);
      end
   endtask

   // Reduced-precision word lengths: B=2, B=4 (code 01) and B=4 (code 11)
   task automatic test_precision();
      act_v[0] = 7; wgt_v[0] = 1;
      act_v[1] = 4; wgt_v[1] = -2;
      applyStimulus(2, 2'b10, 0, 0, 0, 1'b0);
      checks++;
      if (r_res !== ACC_W'(-1) || r_lat !== 10 || r_en !== 6) begin
         failures++;
         $display("[TB] FAIL prec10 got=%0d lat%0d en%0d exp=-1 lat10 en6", $signed(r_res), r_lat, r_en);
      end
      checks++;
      if (r_prec_bad !== 0 || r_rdy_bad !== 0) begin
         failures++;
         $display("[TB] FAIL prec10_ctrl got=%0d/%0d exp=0/0", r_prec_bad, r_rdy_bad);
      end
      act_v[0] = 2; wgt_v[0] = -3;
      act_v[1] = 5; wgt_v[1] = 3;
      applyStimulus(2, 2'b01, 0, 0, 0, 1'b0);
      checks++;
      if (r_res !== ACC_W'(9) || r_lat !== 16 || r_en !== 12) begin
         failures++;
         $display("[TB] FAIL prec01 got=%0d lat%0d en%0d exp=9 lat16 en12", $signed(r_res), r_lat, r_en);
      end
      act_v[0] = 3; wgt_v[0] = -3;
      applyStimulus(1, 2'b11, 0, 0, 0, 1'b0);
      checks++;
      if (r_res !== ACC_W'(-9) || r_lat !== 12 || r_en !== 8 || r_prec_bad !== 0) begin
         failures++;
         $display("[TB] FAIL prec11 got=%0d lat%0d en%0d exp=-9 lat12 en8", $signed(r_res), r_lat, r_en);
      end
   endtask

   // Reset in the middle of a job aborts it; the following job starts clean
   task automatic test_midrun_reset();
      @(negedge clk);
      start = 1'b1; vec_len = LEN_W'(3); prec_level = 2'b01;
      in_valid = 1'b1; in_act = 8'd9; in_wgt = 8'd9; out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if (mac_en !== 1'b1 || busy !== 1'b1) begin
         failures++;
         $display("[TB] FAIL abort_in_run got=en%b busy%b exp=en1 busy1", mac_en, busy);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({busy, in_ready, mac_en, out_valid} !== 4'b0000 || mac_clr !== 1'b1) begin
         failures++;
         $display("[TB] FAIL abort_strobes got=%b clr%b exp=0000 clr1", {busy, in_ready, mac_en, out_valid}, mac_clr);
      end
      checks++;
      if ({mac_act, mac_wgt, mac_prec} !== 18'd0 || out_result !== '0 || out_pairs !== '0) begin
         failures++;
         $display("[TB] FAIL abort_regs got=%h/%h/%b/%0d/%0d exp=all_zero", mac_act, mac_wgt, mac_prec, out_result, out_pairs);
      end
      rst = 1'b0;
      in_valid = 1'b0;
      act_v[0] = 2; wgt_v[0] = 2;
      applyStimulus(1, 2'b00, 0, 0, 0, 1'b0);
      checks++;
      if (r_res !== ACC_W'(4) || r_pairs !== LEN_W'(1) || r_lat !== 20 || r_en !== 16) begin
         failures++;
         $display("[TB] FAIL after_abort got=%0d/%0d lat%0d en%0d exp=4/1 lat20 en16", $signed(r_res), r_pairs, r_lat, r_en);
      end
   endtask

   // Empty job goes straight to DONE and holds a zero result under backpressure
   task automatic test_zero_len();
      applyStimulus(0, 2'b00, 0, 0, 4, 1'b0);
      checks++;
      if (r_res !== '0 || r_pairs !== '0) begin
         failures++;
         $display("[TB] FAIL zero_result got=%0d/%0d exp=0/0", $signed(r_res), r_pairs);
      end
      checks++;
      if (r_lat !== 1 || r_en !== 0) begin
         failures++;
         $display("[TB] FAIL zero_timing got=lat%0d en%0d exp=lat1 en0", r_lat, r_en);
      end
      checks++;
      if (r_vcnt !== 5 || r_unstable !== 0 || r_post_bad !== 0) begin
         failures++;
         $display("[TB] FAIL zero_hold got=v%0d u%0d p%0d exp=v5 u0 p0", r_vcnt, r_unstable, r_post_bad);
      end
   endtask

   // Test sequence
   initial begin
      $display("[TB] mac_seq_ctrl directed tests");
      test_reset();
      test_single();
      test_back_to_back();
      test_stall();
      test_precision();
      test_midrun_reset();
      test_zero_len();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
